axil_protocol_monitor: RTL and testbench
========================================

# axil_protocol_monitor

Synthesizable, parametrised AXI4-lite protocol monitor. It watches one AXI4-lite link passively, tracks outstanding transactions per channel, and latches sticky error flags for handshake, ordering, overflow and timeout violations. It sits alongside any AXI4-lite master/slave pair in simulation, on FPGA debug builds, or under formal as an assertion target. It never drives the bus.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address bus width in bits
- STRB_WIDTH, DATA_WIDTH/8, wstrb width
- OSTD_MAX, 16, maximum legal outstanding transactions per channel (≥1)
- STALL_MAX, 16, maximum cycles any valid may wait for ready (≥2)
- TIMEOUT_MAX, 256, maximum cycles a request may wait for its response (≥2)

Ports:
- clk, input, 1, sole clock; all logic on rising edge
- rst, input, 1, synchronous, active-high reset
- mon_axil_aw{addr,prot,valid,ready}, input, ADDR_WIDTH/3/1/1, observed AW channel
- mon_axil_w{data,strb,valid,ready}, input, DATA_WIDTH/STRB_WIDTH/1/1, observed W channel
- mon_axil_b{resp,valid,ready}, input, 2/1/1, observed B channel
- mon_axil_ar{addr,prot,valid,ready}, input, ADDR_WIDTH/3/1/1, observed AR channel
- mon_axil_r{data,resp,valid,ready}, input, DATA_WIDTH/2/1/1, observed R channel
- err_clear, input, 1, clears err_flags and err_first
- aw_outstanding, w_outstanding, ar_outstanding, output, $clog2(OSTD_MAX+1), live counts
- err_flags, output, 10, sticky error bits (below)
- err_first, output, 4, index of first flag set since reset/clear; 4'hF when none
- err_valid, output, 1, OR of err_flags

## Operation
- Counters: AW handshake +1 to aw_outstanding; W handshake +1 to w_outstanding; B handshake −1 to both; AR +1 / R handshake −1 to ar_outstanding. Same-cycle inc and dec: unchanged. Saturate at OSTD_MAX and at 0.
- Error bits, each set on detection, sticky:
  - 0/1/2: AW/W/AR valid dropped or payload (addr+prot / data+strb / addr+prot) changed after valid && !ready previous cycle
  - 3/4: B/R valid dropped or payload changed while stalled
  - 5: bvalid high while aw_outstanding==0 or w_outstanding==0
  - 6: rvalid high while ar_outstanding==0
  - 7: handshake would exceed OSTD_MAX on any counter
  - 8: any of five channels stalled (valid && !ready) STALL_MAX consecutive cycles
  - 9: write (min(aw,w)>0) or read (ar>0) pending TIMEOUT_MAX cycles with no B/R handshake
- Stability checks use previous-cycle registers cleared by reset; no stability check on first cycle after reset.
- Response-timeout counters reset on matching response handshake or when pending count is 0; saturate at TIMEOUT_MAX.
- err_first: loaded with lowest-index newly set bit when err_flags==0; held until clear.
- err_clear with simultaneous new violation: new violation wins (set and err_first loaded).

## Timing
- Reset: all counters 0, err_flags 0, err_valid 0, err_first 4'hF, previous-cycle registers 0.
- Counters update one cycle after the handshake cycle.
- err_flags/err_first register one cycle after the violating cycle; err_valid is combinational from err_flags (same cycle as flag).
- Stall bit 8 sets the cycle after the STALL_MAXth stalled cycle.
- rst mid-operation overrides everything; inputs during rst are ignored.

## Configuration
- AXIL_MON_TIMEOUT_EN defined: stall and response-timeout counters built; bits 8 and 9 active.
- Undefined: counters omitted, bits 8 and 9 tied 0, STALL_MAX/TIMEOUT_MAX unused.

## Test plan
- Legal traffic: 4 writes, 4 reads, responses 3 cycles later -> counters peak at 4, return to 0, err_flags 0, err_first 4'hF.
- awvalid held 2 cycles with awready low, awaddr changes 0x100->0x104 -> err_flags[0]=1 next cycle, err_first=0, err_valid=1.
- bvalid asserted with no AW/W accepted -> err_flags[5]=1; rvalid with ar_outstanding 0 -> err_flags[6]=1, err_first stays 5.
- OSTD_MAX=4, 5 AR handshakes without R -> ar_outstanding saturates at 4, err_flags[7]=1.
- With AXIL_MON_TIMEOUT_EN, STALL_MAX=16: arvalid high, arready low 16 cycles -> err_flags[8]=1 on cycle 17; without macro -> bit 8 stays 0.
- err_clear pulsed same cycle as new bit-1 violation -> err_flags==2'b10 in low bits, err_first=1; rst mid-burst -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/axil_protocol_monitor.sv
// axil_protocol_monitor: passive AXI4-lite checker with sticky error flags; define AXIL_MON_TIMEOUT_EN to build stall/response-timeout checks (bits 8/9)
module axil_protocol_monitor #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int OSTD_MAX = 16,
  parameter int STALL_MAX = 16,
  parameter int TIMEOUT_MAX = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH-1:0]             mon_axil_awaddr,
  input  logic [2:0]                        mon_axil_awprot,
  input  logic                              mon_axil_awvalid,
  input  logic                              mon_axil_awready,
  input  logic [DATA_WIDTH-1:0]             mon_axil_wdata,
  input  logic [STRB_WIDTH-1:0]             mon_axil_wstrb,
  input  logic                              mon_axil_wvalid,
  input  logic                              mon_axil_wready,
  input  logic [1:0]                        mon_axil_bresp,
  input  logic                              mon_axil_bvalid,
  input  logic                              mon_axil_bready,
  input  logic [ADDR_WIDTH-1:0]             mon_axil_araddr,
  input  logic [2:0]                        mon_axil_arprot,
  input  logic                              mon_axil_arvalid,
  input  logic                              mon_axil_arready,
  input  logic [DATA_WIDTH-1:0]             mon_axil_rdata,
  input  logic [1:0]                        mon_axil_rresp,
  input  logic                              mon_axil_rvalid,
  input  logic                              mon_axil_rready,
  input  logic                              err_clear,
  output logic [$clog2(OSTD_MAX+1)-1:0]     aw_outstanding,
  output logic [$clog2(OSTD_MAX+1)-1:0]     w_outstanding,
  output logic [$clog2(OSTD_MAX+1)-1:0]     ar_outstanding,
  output logic [9:0]                        err_flags,
  output logic [3:0]                        err_first,
  output logic                              err_valid
);
  localparam int CW = $clog2(OSTD_MAX + 1);
  localparam logic [CW-1:0] OMAX = CW'(OSTD_MAX);
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
  logic [ADDR_WIDTH+2:0] p_aw, p_ar;
  logic [DATA_WIDTH+STRB_WIDTH-1:0] p_w;
  logic [1:0] p_b;
  logic [DATA_WIDTH+1:0] p_r;
  logic [9:0] new_err;
  logic [3:0] low;
  assign aw_hs = mon_axil_awvalid & mon_axil_awready;
  assign w_hs = mon_axil_wvalid & mon_axil_wready;
  assign b_hs = mon_axil_bvalid & mon_axil_bready;
  assign ar_hs = mon_axil_arvalid & mon_axil_arready;
  assign r_hs = mon_axil_rvalid & mon_axil_rready;
  function automatic logic [CW-1:0] bump(input logic [CW-1:0] c, input logic inc, input logic dec);
    return inc == dec ? c : inc ? (c == OMAX ? c : c + 1'b1) : (c == '0 ? c : c - 1'b1);
  endfunction
  always_ff @(posedge clk)
    if (rst) begin
      aw_outstanding <= '0;
      w_outstanding <= '0;
      ar_outstanding <= '0;
      {p_awv, p_awr, p_aw} <= '0;
      {p_wv, p_wr, p_w} <= '0;
      {p_bv, p_br, p_b} <= '0;
      {p_arv, p_arr, p_ar} <= '0;
      {p_rv, p_rr, p_r} <= '0;
    end else begin
      aw_outstanding <= bump(aw_outstanding, aw_hs, b_hs);
      w_outstanding <= bump(w_outstanding, w_hs, b_hs);
      ar_outstanding <= bump(ar_outstanding, ar_hs, r_hs);
      {p_awv, p_awr, p_aw} <= {mon_axil_awvalid, mon_axil_awready, mon_axil_awaddr, mon_axil_awprot};
      {p_wv, p_wr, p_w} <= {mon_axil_wvalid, mon_axil_wready, mon_axil_wdata, mon_axil_wstrb};
      {p_bv, p_br, p_b} <= {mon_axil_bvalid, mon_axil_bready, mon_axil_bresp};
      {p_arv, p_arr, p_ar} <= {mon_axil_arvalid, mon_axil_arready, mon_axil_araddr, mon_axil_arprot};
      {p_rv, p_rr, p_r} <= {mon_axil_rvalid, mon_axil_rready, mon_axil_rdata, mon_axil_rresp};
    end
  assign new_err[0] = p_awv & ~p_awr & (~mon_axil_awvalid | ({mon_axil_awaddr, mon_axil_awprot} != p_aw));
  assign new_err[1] = p_wv & ~p_wr & (~mon_axil_wvalid | ({mon_axil_wdata, mon_axil_wstrb} != p_w));
  assign new_err[2] = p_arv & ~p_arr & (~mon_axil_arvalid | ({mon_axil_araddr, mon_axil_arprot} != p_ar));
  assign new_err[3] = p_bv & ~p_br & (~mon_axil_bvalid | (mon_axil_bresp != p_b));
  assign new_err[4] = p_rv & ~p_rr & (~mon_axil_rvalid | ({mon_axil_rdata, mon_axil_rresp} != p_r));
  assign new_err[5] = mon_axil_bvalid & (aw_outstanding == '0 | w_outstanding == '0);
  assign new_err[6] = mon_axil_rvalid & (ar_outstanding == '0);
  assign new_err[7] = (aw_hs & ~b_hs & aw_outstanding == OMAX) | (w_hs & ~b_hs & w_outstanding == OMAX) | (ar_hs & ~r_hs & ar_outstanding == OMAX);
`ifdef AXIL_MON_TIMEOUT_EN
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_MAX + 1);
  logic [4:0] stl, st_vec;
  logic [TW-1:0] wr_cnt, rd_cnt;
  logic wr_pend, rd_pend;
  assign stl = {mon_axil_awvalid & ~mon_axil_awready, mon_axil_wvalid & ~mon_axil_wready, mon_axil_bvalid & ~mon_axil_bready, mon_axil_arvalid & ~mon_axil_arready, mon_axil_rvalid & ~mon_axil_rready};
  assign wr_pend = aw_outstanding != '0 && w_outstanding != '0;
  assign rd_pend = ar_outstanding != '0;
  for (genvar s = 0; s < 5; s++) begin : g_stall
    logic [SW-1:0] cnt;
    always_ff @(posedge clk)
      cnt <= rst | ~stl[s] ? '0 : cnt == SW'(STALL_MAX) ? cnt : cnt + 1'b1;
    assign st_vec[s] = stl[s] & (cnt >= SW'(STALL_MAX - 1));
  end
  always_ff @(posedge clk) begin
    wr_cnt <= rst | b_hs | ~wr_pend ? '0 : wr_cnt == TW'(TIMEOUT_MAX) ? wr_cnt : wr_cnt + 1'b1;
    rd_cnt <= rst | r_hs | ~rd_pend ? '0 : rd_cnt == TW'(TIMEOUT_MAX) ? rd_cnt : rd_cnt + 1'b1;
  end
  assign new_err[8] = |st_vec;
  assign new_err[9] = (wr_pend & ~b_hs & (wr_cnt >= TW'(TIMEOUT_MAX - 1))) | (rd_pend & ~r_hs & (rd_cnt >= TW'(TIMEOUT_MAX - 1)));
`else
  assign new_err[9:8] = {TIMEOUT_MAX < 0, STALL_MAX < 0};
`endif
  always_comb begin
    low = 4'hF;
    for (int i = 9; i >= 0; i--) low = new_err[i] ? 4'(i) : low;
  end
  always_ff @(posedge clk)
    if (rst) begin
      err_flags <= '0;
      err_first <= 4'hF;
    end else begin
      err_flags <= (err_clear ? 10'd0 : err_flags) | new_err;
      err_first <= (err_clear | ~|err_flags) & |new_err ? low : err_clear ? 4'hF : err_first;
    end
  assign err_valid = |err_flags;
endmodule

// File: tb/tb_axil_protocol_monitor.sv
// tb_axil_protocol_monitor: table vectors, corner sequences and randomized traffic checked against a behavioural model
module tb_axil_protocol_monitor;
  localparam int OSTD = 4;
  localparam int STALL = 16;
  localparam int TMO = 40;
`ifdef AXIL_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] awaddr; logic [2:0] awprot; logic awvalid, awready;
    logic [31:0] wdata; logic [3:0] wstrb; logic wvalid, wready;
    logic [1:0] bresp; logic bvalid, bready;
    logic [31:0] araddr; logic [2:0] arprot; logic arvalid, arready;
    logic [31:0] rdata; logic [1:0] rresp; logic rvalid, rready;
    logic clr;
  } bus_t;
  typedef struct { bus_t i; int aw, w, ar; logic [9:0] flags; logic [3:0] first; } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bus_t in = '0;
  logic [2:0] aw_o, w_o, ar_o;
  logic [9:0] flags_o;
  logic [3:0] first_o;
  logic valid_o;
  int checks = 0;
  int errors = 0;
  bus_t p;
  int m_aw, m_w, m_ar, wr_wait, rd_wait;
  int run [5];
  logic [9:0] m_flags;
  logic [3:0] m_first;
  vec_t tbl [$];
  always #5 clk = ~clk;
  axil_protocol_monitor #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4), .OSTD_MAX(OSTD), .STALL_MAX(STALL), .TIMEOUT_MAX(TMO)) dut (
    .clk(clk), .rst(rst),
    .mon_axil_awaddr(in.awaddr), .mon_axil_awprot(in.awprot), .mon_axil_awvalid(in.awvalid), .mon_axil_awready(in.awready),
    .mon_axil_wdata(in.wdata), .mon_axil_wstrb(in.wstrb), .mon_axil_wvalid(in.wvalid), .mon_axil_wready(in.wready),
    .mon_axil_bresp(in.bresp), .mon_axil_bvalid(in.bvalid), .mon_axil_bready(in.bready),
    .mon_axil_araddr(in.araddr), .mon_axil_arprot(in.arprot), .mon_axil_arvalid(in.arvalid), .mon_axil_arready(in.arready),
    .mon_axil_rdata(in.rdata), .mon_axil_rresp(in.rresp), .mon_axil_rvalid(in.rvalid), .mon_axil_rready(in.rready),
    .err_clear(in.clr),
    .aw_outstanding(aw_o), .w_outstanding(w_o), .ar_outstanding(ar_o),
    .err_flags(flags_o), .err_first(first_o), .err_valid(valid_o)
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic int clamp(input int x);
    return x < 0 ? 0 : x > OSTD ? OSTD : x;
  endfunction
  task automatic model_reset();
    p = '0;
    m_aw = 0; m_w = 0; m_ar = 0; wr_wait = 0; rd_wait = 0;
    for (int k = 0; k < 5; k++) run[k] = 0;
    m_flags = '0;
    m_first = 4'hF;
  endtask
  task automatic model_step();
    logic [9:0] v;
    logic [9:0] base;
    bit st [5];
    int awhs, whs, bhs, arhs, rhs, lo;
    if (rst) begin
      model_reset();
      return;
    end
    awhs = int'(in.awvalid && in.awready);
    whs = int'(in.wvalid && in.wready);
    bhs = int'(in.bvalid && in.bready);
    arhs = int'(in.arvalid && in.arready);
    rhs = int'(in.rvalid && in.rready);
    v = '0;
    v[0] = p.awvalid && !p.awready && (!in.awvalid || in.awaddr != p.awaddr || in.awprot != p.awprot);
    v[1] = p.wvalid && !p.wready && (!in.wvalid || in.wdata != p.wdata || in.wstrb != p.wstrb);
    v[2] = p.arvalid && !p.arready && (!in.arvalid || in.araddr != p.araddr || in.arprot != p.arprot);
    v[3] = p.bvalid && !p.bready && (!in.bvalid || in.bresp != p.bresp);
    v[4] = p.rvalid && !p.rready && (!in.rvalid || in.rdata != p.rdata || in.rresp != p.rresp);
    v[5] = in.bvalid && (m_aw == 0 || m_w == 0);
    v[6] = in.rvalid && m_ar == 0;
    v[7] = (awhs == 1 && bhs == 0 && m_aw == OSTD) || (whs == 1 && bhs == 0 && m_w == OSTD) || (arhs == 1 && rhs == 0 && m_ar == OSTD);
    st[0] = in.awvalid && !in.awready;
    st[1] = in.wvalid && !in.wready;
    st[2] = in.bvalid && !in.bready;
    st[3] = in.arvalid && !in.arready;
    st[4] = in.rvalid && !in.rready;
    for (int k = 0; k < 5; k++) begin
      run[k] = st[k] ? run[k] + 1 : 0;
      if (TO_EN && run[k] >= STALL) v[8] = 1'b1;
    end
    wr_wait = (m_aw > 0 && m_w > 0 && bhs == 0) ? wr_wait + 1 : 0;
    rd_wait = (m_ar > 0 && rhs == 0) ? rd_wait + 1 : 0;
    if (TO_EN && (wr_wait >= TMO || rd_wait >= TMO)) v[9] = 1'b1;
    m_aw = clamp(m_aw + awhs - bhs);
    m_w = clamp(m_w + whs - bhs);
    m_ar = clamp(m_ar + arhs - rhs);
    base = in.clr ? 10'd0 : m_flags;
    lo = 15;
    for (int k = 9; k >= 0; k--) if (v[k]) lo = k;
    if (base == 0 && v != 0) m_first = 4'(lo);
    else if (in.clr) m_first = 4'hF;
    m_flags = base | v;
    p = in;
  endtask
  task automatic step(input bus_t x, input logic r);
    in = x;
    rst = r;
    @(posedge clk);
    model_step();
    #1;
    chk("aw_outstanding", 32'(aw_o), 32'(m_aw));
    chk("w_outstanding", 32'(w_o), 32'(m_w));
    chk("ar_outstanding", 32'(ar_o), 32'(m_ar));
    chk("err_flags", 32'(flags_o), 32'(m_flags));
    chk("err_first", 32'(first_o), 32'(m_first));
    chk("err_valid", 32'(valid_o), 32'(|m_flags));
  endtask
  function automatic bus_t mk(input bit awv, awr, input logic [31:0] awa, input bit wv, wr, bv, br, arv, arr, rv, rr, clr);
    bus_t b = '0;
    b.awaddr = awa; b.awprot = 3'd1; b.awvalid = awv; b.awready = awr;
    b.wdata = 32'hA5A5_0000; b.wstrb = 4'hF; b.wvalid = wv; b.wready = wr;
    b.bvalid = bv; b.bready = br;
    b.araddr = 32'h200; b.arvalid = arv; b.arready = arr;
    b.rdata = 32'h1234; b.rvalid = rv; b.rready = rr;
    b.clr = clr;
    return b;
  endfunction
  task automatic add(input bus_t i, input int aw, w, ar, input logic [9:0] f, input logic [3:0] first);
    vec_t t;
    t.i = i; t.aw = aw; t.w = w; t.ar = ar; t.flags = f; t.first = first;
    tbl.push_back(t);
  endtask
  initial begin
    bus_t x;
    int rps [3] = '{10, 50, 90};
    int rp = 50;
    add(mk(1,1,32'h10, 1,1, 0,0, 1,1, 0,0, 0), 1, 1, 1, 10'h000, 4'hF);
    add(mk(0,0,32'h0,  0,0, 0,0, 0,0, 0,0, 0), 1, 1, 1, 10'h000, 4'hF);
    add(mk(0,0,32'h0,  0,0, 1,1, 0,0, 1,1, 0), 0, 0, 0, 10'h000, 4'hF);
    add(mk(1,0,32'h100,0,0, 0,0, 0,0, 0,0, 0), 0, 0, 0, 10'h000, 4'hF);
    add(mk(1,0,32'h104,0,0, 0,0, 0,0, 0,0, 0), 0, 0, 0, 10'h001, 4'h0);
    add(mk(1,1,32'h104,0,0, 0,0, 0,0, 0,0, 0), 1, 0, 0, 10'h001, 4'h0);
    add(mk(0,0,32'h0,  0,0, 1,0, 0,0, 0,0, 0), 1, 0, 0, 10'h021, 4'h0);
    add(mk(0,0,32'h0,  0,0, 0,0, 0,0, 0,0, 1), 1, 0, 0, 10'h008, 4'h3);
    add(mk(0,0,32'h0,  0,0, 0,0, 0,0, 0,0, 1), 1, 0, 0, 10'h000, 4'hF);
    add(mk(0,0,32'h0,  0,0, 1,1, 0,0, 0,0, 0), 0, 0, 0, 10'h020, 4'h5);
    add(mk(0,0,32'h0,  0,0, 0,0, 0,0, 1,1, 0), 0, 0, 0, 10'h060, 4'h5);
    add(mk(0,0,32'h0,  0,0, 0,0, 0,0, 0,0, 0), 0, 0, 0, 10'h060, 4'h5);
    step('0, 1'b1);
    step('0, 1'b1);
    chk("reset_flags", 32'(flags_o), 32'h0);
    chk("reset_first", 32'(first_o), 32'hF);
    chk("reset_valid", 32'(valid_o), 32'h0);
    chk("reset_counts", 32'({aw_o, w_o, ar_o}), 32'h0);
    for (int k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i, 1'b0);
      chk($sformatf("tbl%0d_aw", k), 32'(aw_o), 32'(tbl[k].aw));
      chk($sformatf("tbl%0d_w", k), 32'(w_o), 32'(tbl[k].w));
      chk($sformatf("tbl%0d_ar", k), 32'(ar_o), 32'(tbl[k].ar));
      chk($sformatf("tbl%0d_flags", k), 32'(flags_o), 32'(tbl[k].flags));
      chk($sformatf("tbl%0d_first", k), 32'(first_o), 32'(tbl[k].first));
      chk($sformatf("tbl%0d_valid", k), 32'(valid_o), 32'(|tbl[k].flags));
    end
    step('0, 1'b1);
    for (int k = 0; k < 4; k++) step(mk(1,1,32'h10 + 32'(4*k), 1,1, 0,0, 1,1, 0,0, 0), 1'b0);
    chk("legal_peak_aw", 32'(aw_o), 32'd4);
    chk("legal_peak_w", 32'(w_o), 32'd4);
    chk("legal_peak_ar", 32'(ar_o), 32'd4);
    step('0, 1'b0);
    step('0, 1'b0);
    for (int k = 0; k < 4; k++) step(mk(0,0,32'h0, 0,0, 1,1, 0,0, 1,1, 0), 1'b0);
    chk("legal_end_counts", 32'({aw_o, w_o, ar_o}), 32'h0);
    chk("legal_end_flags", 32'(flags_o), 32'h0);
    chk("legal_end_first", 32'(first_o), 32'hF);
    step('0, 1'b1);
    for (int k = 0; k < 4; k++) step(mk(0,0,32'h0, 0,0, 0,0, 1,1, 0,0, 0), 1'b0);
    chk("ovf_ar_at_max", 32'(ar_o), 32'd4);
    chk("ovf_no_flag_yet", 32'(flags_o), 32'h0);
    step(mk(0,0,32'h0, 0,0, 0,0, 1,1, 0,0, 0), 1'b0);
    chk("ovf_ar_saturated", 32'(ar_o), 32'd4);
    chk("ovf_flag7", 32'(flags_o), 32'h080);
    chk("ovf_first", 32'(first_o), 32'd7);
    step('0, 1'b1);
    for (int k = 0; k < STALL - 1; k++) step(mk(0,0,32'h0, 0,0, 0,0, 1,0, 0,0, 0), 1'b0);
    chk("stall_before_max", 32'(flags_o[8]), 32'h0);
    step(mk(0,0,32'h0, 0,0, 0,0, 1,0, 0,0, 0), 1'b0);
    chk("stall_bit8", 32'(flags_o[8]), 32'(TO_EN));
    chk("stall_first", 32'(first_o), TO_EN ? 32'd8 : 32'hF);
    step('0, 1'b1);
    step(mk(0,0,32'h0, 0,0, 0,0, 1,1, 0,0, 0), 1'b0);
    for (int k = 0; k < TMO - 1; k++) step('0, 1'b0);
    chk("timeout_before_max", 32'(flags_o[9]), 32'h0);
    step('0, 1'b0);
    chk("timeout_bit9", 32'(flags_o[9]), 32'(TO_EN));
    step('0, 1'b1);
    step(mk(0,0,32'h0, 0,0, 0,0, 0,0, 1,1, 0), 1'b0);
    chk("clr_pre_flags", 32'(flags_o), 32'h040);
    step(mk(0,0,32'h0, 1,0, 0,0, 0,0, 0,0, 0), 1'b0);
    x = mk(0,0,32'h0, 1,0, 0,0, 0,0, 0,0, 1);
    x.wdata = 32'hA5A5_0001;
    step(x, 1'b0);
    chk("clr_vs_new_flags", 32'(flags_o), 32'h002);
    chk("clr_vs_new_first", 32'(first_o), 32'd1);
    chk("clr_vs_new_valid", 32'(valid_o), 32'd1);
    step('0, 1'b1);
    step(mk(1,1,32'h40, 1,1, 0,0, 1,1, 0,0, 0), 1'b0);
    step(mk(1,0,32'h44, 1,0, 1,0, 1,0, 1,0, 0), 1'b0);
    step(mk(0,0,32'h48, 1,0, 0,0, 0,0, 0,0, 0), 1'b0);
    chk("burst_flags_set", 32'(valid_o), 32'd1);
    step(mk(1,1,32'h4C, 0,0, 1,1, 1,1, 1,1, 0), 1'b1);
    chk("midrst_counts", 32'({aw_o, w_o, ar_o}), 32'h0);
    chk("midrst_flags", 32'(flags_o), 32'h0);
    chk("midrst_first", 32'(first_o), 32'hF);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    for (int c = 0; c < 4000; c++) begin
      if (c % 256 == 0) rp = rps[$urandom_range(0, 2)];
      x = in;
      if (!(x.awvalid && !x.awready) || $urandom_range(0, 15) == 0) begin
        x.awvalid = 1'($urandom_range(0, 1));
        x.awaddr = 32'($urandom_range(0, 3)) << 2;
        x.awprot = 3'($urandom_range(0, 1));
      end
      x.awready = $urandom_range(0, 99) < rp;
      if (!(x.wvalid && !x.wready) || $urandom_range(0, 15) == 0) begin
        x.wvalid = 1'($urandom_range(0, 1));
        x.wdata = 32'($urandom_range(0, 3));
        x.wstrb = 4'($urandom_range(0, 15));
      end
      x.wready = $urandom_range(0, 99) < rp;
      if (!(x.bvalid && !x.bready) || $urandom_range(0, 15) == 0) begin
        x.bvalid = (m_aw > 0 && m_w > 0) ? 1'($urandom_range(0, 1)) : $urandom_range(0, 31) == 0;
        x.bresp = 2'($urandom_range(0, 3));
      end
      x.bready = $urandom_range(0, 99) < rp;
      if (!(x.arvalid && !x.arready) || $urandom_range(0, 15) == 0) begin
        x.arvalid = 1'($urandom_range(0, 1));
        x.araddr = 32'($urandom_range(0, 3)) << 2;
        x.arprot = 3'($urandom_range(0, 1));
      end
      x.arready = $urandom_range(0, 99) < rp;
      if (!(x.rvalid && !x.rready) || $urandom_range(0, 15) == 0) begin
        x.rvalid = m_ar > 0 ? 1'($urandom_range(0, 1)) : $urandom_range(0, 31) == 0;
        x.rdata = 32'($urandom_range(0, 3));
        x.rresp = 2'($urandom_range(0, 3));
      end
      x.rready = $urandom_range(0, 99) < rp;
      x.clr = $urandom_range(0, 15) == 0;
      step(x, $urandom_range(0, 499) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
